// File: rtl/finv_arb_pkg.sv
// finv_arb_pkg: shared constants and helpers for the finv arbiter.
//   FloatW      width of a single-precision operand/result
//   EntryYLsb   LSB of the result field inside a FIFO entry {id, y}
//   EntryIdLsb  LSB of the requester-id field inside a FIFO entry {id, y}
//   MaxReq      widest request vector pick_first() accepts
//   pick_first  position of the one-hot priority winner in a (rotated) request vector
package finv_arb_pkg;

    localparam int unsigned FloatW     = 32;
    localparam int unsigned EntryYLsb  = 0;
    localparam int unsigned EntryIdLsb = FloatW;
    localparam int unsigned MaxReq     = 32;

    // Lowest set bit wins; returns MaxReq when the vector is empty.
    function automatic int unsigned pick_first(input logic [MaxReq-1:0] req);
        int unsigned pos;
        pos = MaxReq;
        for (int unsigned i = MaxReq; i > 0; i--) begin
            if (req[i-1]) begin
                pos = i - 1;
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/finv_arb_fifo.sv
// finv_arb_fifo: synchronous result FIFO with occupancy count and registered head.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   push_i          write push_data_i at the tail (caller guarantees not full)
//   push_data_i     entry to write
//   pop_i           drop the head (ignored when empty)
//   head_valid_o    FIFO holds at least one entry
//   head_data_o     head entry, read straight from storage flops
//   count_o         number of stored entries
module finv_arb_fifo #(
    parameter int unsigned Width = 34,
    parameter int unsigned Depth = 4,
    parameter int unsigned CntW  = $clog2(Depth + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] push_data_i,
    input  logic             pop_i,
    output logic             head_valid_o,
    output logic [Width-1:0] head_data_o,
    output logic [CntW-1:0]  count_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Depth-1:0][Width-1:0] mem_q, mem_d;
    logic [PtrW-1:0]             wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]             rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]             count_q, count_d;
    logic                        do_pop;

    // Pointers wrap modulo Depth, which need not be a power of two.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
    endfunction

    assign head_valid_o = (count_q != '0);
    assign head_data_o  = mem_q[rd_ptr_q];
    assign count_o      = count_q;
    assign do_pop       = pop_i && head_valid_o;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        count_d = count_q + CntW'(push_i) - CntW'(do_pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/finv_arbiter.sv
// finv_arbiter: shares one pipelined reciprocal unit (latency LAT) among NREQ requesters.
// At most one operand issues per cycle; the issuing requester id rides a LAT-deep tag pipe
// alongside the unit and is paired with the result into a credit-guarded FIFO, so downstream
// backpressure never drops a result. Results leave in issue order.
// Configuration macro:
//   FINV_ARB_RR_EN  defined: round-robin priority; undefined: fixed priority, lowest index wins.
// Ports:
//   clk, rstn    clock, asynchronous active-low reset
//   req_valid    per-requester operand valid
//   req_x        operands, requester i at [32*i +: 32]
//   req_ready    one-hot grant (transfer on valid & ready)
//   fu_x         operand to the shared finv (0 when nothing issues)
//   fu_y         finv result, LAT cycles after fu_x
//   resp_valid   FIFO head valid
//   resp_id      requester id of the head
//   resp_y       reciprocal at the head
//   resp_ready   downstream accepts the head
//   idle         nothing in flight and FIFO empty
module finv_arbiter
    import finv_arb_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned IDW   = 2,
    parameter int unsigned LAT   = 1,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [FloatW*NREQ-1:0] req_x,
    output logic [NREQ-1:0]        req_ready,
    output logic [FloatW-1:0]      fu_x,
    input  logic [FloatW-1:0]      fu_y,
    output logic                   resp_valid,
    output logic [IDW-1:0]         resp_id,
    output logic [FloatW-1:0]      resp_y,
    input  logic                   resp_ready,
    output logic                   idle
);

    localparam int unsigned CntW   = $clog2(DEPTH + 1);
    localparam int unsigned EntryW = IDW + FloatW;

    logic [LAT-1:0]          tag_vld_q, tag_vld_d;
    logic [LAT-1:0][IDW-1:0] tag_id_q, tag_id_d;
    logic [CntW-1:0]         fifo_count;
    logic [CntW-1:0]         inflight;
    logic [CntW:0]           occupancy;
    logic                    have_credit;
    logic [NREQ-1:0]         rotated;
    logic [IDW-1:0]          grant_idx;
    logic                    grant_any;
    logic                    push;
    logic [EntryW-1:0]       push_data;
    logic                    pop;
    logic [EntryW-1:0]       head_data;

    // ---------------------------------------------------------------- credit
    always_comb begin
        inflight = '0;
        for (int unsigned k = 0; k < LAT; k++) begin
            inflight = inflight + CntW'(tag_vld_q[k]);
        end
    end

    // Every in-flight op already owns a FIFO slot, so a capture can never find it full.
    assign occupancy   = {1'b0, fifo_count} + {1'b0, inflight};
    assign have_credit = (occupancy < (CntW + 1)'(DEPTH));

    // ---------------------------------------------------------------- arbitration
`ifdef FINV_ARB_RR_EN
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;

    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] a,
                                                input logic [IDW-1:0] b);
        logic [IDW:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= (IDW + 1)'(NREQ)) begin
            sum = sum - (IDW + 1)'(NREQ);
        end
        return sum[IDW-1:0];
    endfunction

    // Rotate so that bit 0 of the search vector is the requester the pointer names.
    always_comb begin
        rotated = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            rotated[i] = req_valid[wrap_add(IDW'(i), rr_ptr_q)];
        end
    end

    assign grant_idx = wrap_add(IDW'(pick_first(MaxReq'(rotated))), rr_ptr_q);
    assign rr_ptr_d  = grant_any ? wrap_add(grant_idx, IDW'(1)) : rr_ptr_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    assign rotated   = req_valid;
    assign grant_idx = IDW'(pick_first(MaxReq'(rotated)));
`endif

    assign grant_any = (|rotated) && have_credit;

    always_comb begin
        req_ready = '0;
        fu_x      = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant_any && (grant_idx == IDW'(i))) begin
                req_ready[i] = 1'b1;
                fu_x         = req_x[FloatW*i +: FloatW];
            end
        end
    end

    // ---------------------------------------------------------------- tag pipe
    always_comb begin
        tag_vld_d    = tag_vld_q;
        tag_id_d     = tag_id_q;
        tag_vld_d[0] = grant_any;
        tag_id_d[0]  = grant_idx;
        for (int unsigned k = 1; k < LAT; k++) begin
            tag_vld_d[k] = tag_vld_q[k-1];
            tag_id_d[k]  = tag_id_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tag_vld_q <= '0;
            tag_id_q  <= '0;
        end else begin
            tag_vld_q <= tag_vld_d;
            tag_id_q  <= tag_id_d;
        end
    end

    // ---------------------------------------------------------------- result FIFO
    // The last tag stage lines up with fu_y for the same op.
    assign push      = tag_vld_q[LAT-1];
    assign push_data = {tag_id_q[LAT-1], fu_y};
    assign pop       = resp_valid && resp_ready;

    finv_arb_fifo #(
        .Width (EntryW),
        .Depth (DEPTH),
        .CntW  (CntW)
    ) u_fifo (
        .clk_i        (clk),
        .rst_ni       (rstn),
        .push_i       (push),
        .push_data_i  (push_data),
        .pop_i        (pop),
        .head_valid_o (resp_valid),
        .head_data_o  (head_data),
        .count_o      (fifo_count)
    );

    assign resp_id = head_data[EntryIdLsb +: IDW];
    assign resp_y  = head_data[EntryYLsb +: FloatW];
    assign idle    = (inflight == '0) && (fifo_count == '0);

endmodule

// File: tb/tb_finv_arbiter.sv
// tb_finv_arbiter: self-checking bench for finv_arbiter (NREQ=4, LAT=1, DEPTH=4).
// A small finv model drives fu_y; a transaction-level reference (queue of outstanding ops,
// each with the cycle its result becomes visible) predicts grants and responses.
module tb_finv_arbiter;

    localparam int NREQ  = 4;
    localparam int IDW   = 2;
    localparam int LAT   = 1;
    localparam int DEPTH = 4;

    logic              clk;
    logic              rstn;
    logic [NREQ-1:0]   req_valid;
    logic [32*NREQ-1:0] req_x;
    logic [NREQ-1:0]   req_ready;
    logic [31:0]       fu_x;
    logic [31:0]       fu_y;
    logic              resp_valid;
    logic [IDW-1:0]    resp_id;
    logic [31:0]       resp_y;
    logic              resp_ready;
    logic              idle;

    finv_arbiter #(
        .NREQ  (NREQ),
        .IDW   (IDW),
        .LAT   (LAT),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_x      (req_x),
        .req_ready  (req_ready),
        .fu_x       (fu_x),
        .fu_y       (fu_y),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_y     (resp_y),
        .resp_ready (resp_ready),
        .idle       (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Coarse reciprocal: exact for powers of two, exponent-flip approximation otherwise.
    function automatic logic [31:0] finv_ref(input logic [31:0] x);
        logic [7:0] e;
        e = x[30:23];
        if (x[22:0] == 23'd0) return {x[31], 8'(254 - int'(e)), 23'd0};
        return {x[31], 8'(253 - int'(e)), ~x[22:0]};
    endfunction

    logic [31:0] fpipe [LAT];
    always @(posedge clk) begin
        fpipe[0] <= finv_ref(fu_x);
        for (int k = 1; k < LAT; k++) fpipe[k] <= fpipe[k-1];
    end
    assign fu_y = fpipe[LAT-1];

    typedef struct {
        int          id;
        logic [31:0] y;
        int          rdy;
    } exp_t;

    exp_t        q[$];
    bit          pend [NREQ];
    logic [31:0] opx  [NREQ];
    int          rr;
    int          cyc;
    int          n_chk;
    int          n_err;
    int          grants_seen;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic apply_inputs();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]       = pend[i];
            req_x[32*i +: 32]  = opx[i];
        end
    endtask

    // One clock: drive, check every output at the falling edge, advance the model.
    task automatic do_cycle();
        int              exp_g;
        logic [NREQ-1:0] exp_rdy;
        logic [31:0]     exp_fx;
        bit              exp_rv;
        apply_inputs();
        @(negedge clk);
        exp_g = -1;
        if (q.size() < DEPTH) begin
            for (int k = 0; k < NREQ; k++) begin
                int idx;
                idx = (rr + k) % NREQ;
                if (pend[idx] && exp_g < 0) exp_g = idx;
            end
        end
        exp_rdy = (exp_g >= 0) ? (NREQ'(1) << exp_g) : '0;
        exp_fx  = (exp_g >= 0) ? opx[exp_g] : 32'd0;
        exp_rv  = (q.size() > 0) && (q[0].rdy <= cyc);
        if (|(req_ready & req_valid)) grants_seen++;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("fu_x", fu_x, exp_fx);
        chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
        if (exp_rv) begin
            chk("resp_id", 32'(resp_id), 32'(q[0].id));
            chk("resp_y", resp_y, q[0].y);
        end
        chk("idle", 32'(idle), 32'(q.size() == 0));
        if (exp_rv && resp_ready) void'(q.pop_front());
        if (exp_g >= 0) begin
            q.push_back('{id: exp_g, y: finv_ref(opx[exp_g]), rdy: cyc + LAT + 1});
            pend[exp_g] = 1'b0;
`ifdef FINV_ARB_RR_EN
            rr = (exp_g + 1) % NREQ;
`endif
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_fu_x"}, fu_x, 32'd0);
        chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, "_resp_id"}, 32'(resp_id), 32'd0);
        chk({tag, "_resp_y"}, resp_y, 32'd0);
        chk({tag, "_idle"}, 32'(idle), 32'd1);
    endtask

    task automatic raise_all();
        for (int i = 0; i < NREQ; i++) begin
            if (!pend[i]) begin
                pend[i] = 1'b1;
                opx[i]  = $urandom;
            end
        end
    endtask

    int acc_before;

    initial begin
        n_chk = 0; n_err = 0; cyc = 0; rr = 0; grants_seen = 0;
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 1'b0;
            opx[i]  = 32'd0;
        end
        rstn       = 1'b0;
        resp_ready = 1'b0;
        apply_inputs();

        // Reset state
        #12;
        check_reset_values("rst");
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Single op of 2.0: grant same cycle, response two cycles later
        resp_ready = 1'b1;
        pend[0] = 1'b1;
        opx[0]  = 32'h4000_0000;
        do_cycle();
        do_cycle();
        chk("t1_valid", 32'(resp_valid), 32'd1);
        chk("t1_id", 32'(resp_id), 32'd0);
        chk("t1_y", resp_y, 32'h3F00_0000);
        do_cycle();
        do_cycle();

        // All requesters held valid for 8 cycles
        for (int n = 0; n < 8; n++) begin
            raise_all();
            do_cycle();
        end
        // Requester 0 drops out
        for (int n = 0; n < 6; n++) begin
            raise_all();
            pend[0] = 1'b0;
            do_cycle();
        end
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        for (int n = 0; n < 8; n++) do_cycle();

        // Backpressure: exactly DEPTH accepted while resp_ready is low
        resp_ready = 1'b0;
        acc_before = grants_seen;
        for (int n = 0; n < 10; n++) begin
            raise_all();
            do_cycle();
        end
        chk("t4_accepted", 32'(grants_seen - acc_before), 32'(DEPTH));
        resp_ready = 1'b1;
        for (int n = 0; n < 12; n++) begin
            raise_all();
            do_cycle();
        end
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        for (int n = 0; n < 8; n++) do_cycle();

        // Random traffic with random backpressure (covers push+pop at count 3, wrap)
        for (int n = 0; n < 400; n++) begin
            resp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1'b1;
                    opx[i]  = $urandom;
                end
            end
            do_cycle();
        end
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        resp_ready = 1'b1;
        for (int n = 0; n < 8; n++) do_cycle();

        // Reset with one op in flight and two queued
        resp_ready = 1'b0;
        for (int n = 0; n < 3; n++) begin
            pend[1] = 1'b1;
            opx[1]  = $urandom;
            do_cycle();
        end
        chk("pre_rst_busy", 32'(idle), 32'd0);
        rstn = 1'b0;
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        apply_inputs();
        #2;
        check_reset_values("mid_rst");
        q.delete();
        rr = 0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
        for (int n = 0; n < 6; n++) do_cycle();

        // Traffic resumes after reset
        for (int n = 0; n < 40; n++) begin
            resp_ready = ($urandom_range(0, 1) == 1);
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    opx[i]  = $urandom;
                end
            end
            do_cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
